// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryption controller.
package aes_dec_pkg;

    localparam int unsigned NR     = 10;
    localparam int unsigned KIDX_W = 4;
    localparam int unsigned DATA_W = 128;

    localparam logic [KIDX_W-1:0] KIDX_INIT = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] KIDX_LAST = '0;

    typedef logic [DATA_W-1:0] block_t;

    typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} state_e;

    typedef enum logic [1:0] {StepInit, StepRound, StepFinal} step_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/add_round_key.sv
// AddRoundKey: XOR of the block with the selected round key.
module add_round_key
    import aes_dec_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] key_i,
    output logic [DATA_W-1:0] data_o
);

    assign data_o = data_i ^ key_i;

endmodule

// File: rtl/aes_dec_step.sv
// Combinational next-block mux for the INIT, ROUND and FINAL steps.
module aes_dec_step
    import aes_dec_pkg::*;
(
    input  step_e             step_i,
    input  logic [DATA_W-1:0] state_i,
    input  logic [DATA_W-1:0] round_key_i,
    output logic [DATA_W-1:0] state_o
);

    block_t ark, isr, isb, rnd;

    // INIT and FINAL share this key add; FINAL takes it directly, bypassing ISR/ISB.
    add_round_key  u_ark (.data_i(state_i), .key_i(round_key_i), .data_o(ark));
    inv_shift_rows u_isr (.data_i(ark), .data_o(isr));
    inv_sub_bytes  u_isb (.data_i(isr), .data_o(isb));

    decrypt_round u_round (
        .round_key_i(round_key_i),
        .state_i    (state_i),
        .state_o    (rnd)
    );

    always_comb begin
        state_o = rnd;
        unique case (step_i)
            StepInit:  state_o = isb;
            StepRound: state_o = rnd;
            StepFinal: state_o = ark;
            default:   state_o = rnd;
        endcase
    end

endmodule

// File: rtl/decrypt_round.sv
// One full inverse round: AddRoundKey, InvMixColumns, InvShiftRows, InvSubBytes.
module decrypt_round
    import aes_dec_pkg::*;
(
    input  logic [DATA_W-1:0] round_key_i,
    input  logic [DATA_W-1:0] state_i,
    output logic [DATA_W-1:0] state_o
);

    block_t ark, imc, isr;

    add_round_key   u_ark (.data_i(state_i), .key_i(round_key_i), .data_o(ark));
    inv_mix_columns u_imc (.data_i(ark), .data_o(imc));
    inv_shift_rows  u_isr (.data_i(imc), .data_o(isr));
    inv_sub_bytes   u_isb (.data_i(isr), .data_o(state_o));

endmodule

// File: rtl/inv_mix_columns.sv
// InvMixColumns applied independently to each of the four columns.
module inv_mix_columns
    import aes_dec_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data_i[127-32*c -: 8];
        assign a1 = data_i[119-32*c -: 8];
        assign a2 = data_i[111-32*c -: 8];
        assign a3 = data_i[103-32*c -: 8];
        assign data_o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                     ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign data_o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                     ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign data_o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                     ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign data_o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                     ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end

endmodule

// File: rtl/inv_shift_rows.sv
// InvShiftRows on a column-major block (byte 0 in the top bits).
module inv_shift_rows
    import aes_dec_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign data_o[127-8*(r+4*c) -: 8] = data_i[127-8*(r+4*((c-r+4)%4)) -: 8];
        end
    end

endmodule

// File: rtl/inv_sub_bytes.sv
// InvSubBytes, computed as inverse affine followed by GF(2^8) inversion.
module inv_sub_bytes
    import aes_dec_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[8*i +: 8] = inv_sbox(data_i[8*i +: 8]);
    end

endmodule

// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-128 decryption controller: 11 datapath cycles per block, handshakes on both sides.
module aes_dec_iter_ctrl
    import aes_dec_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic [KIDX_W-1:0] key_idx_o,
    input  logic [DATA_W-1:0] round_key_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o
);

    localparam logic [KIDX_W-1:0] KIDX_ONE = KIDX_W'(1);

    state_e            st_q, st_d;
    block_t            state_q, state_d;
    logic [KIDX_W-1:0] rnd_q, rnd_d;
    step_e             step;
    block_t            step_out;

    aes_dec_step u_step (
        .step_i     (step),
        .state_i    (state_q),
        .round_key_i(round_key_i),
        .state_o    (step_out)
    );

    always_comb begin
        st_d        = st_q;
        state_d     = state_q;
        rnd_d       = rnd_q;
        step        = StepRound;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        busy_o      = 1'b0;
        key_idx_o   = KIDX_LAST;
        unique case (st_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    state_d = in_data_i;
                    st_d    = StInit;
                end
            end
            StInit: begin
                busy_o    = 1'b1;
                key_idx_o = KIDX_INIT;
                step      = StepInit;
                state_d   = step_out;
                rnd_d     = KIDX_INIT - KIDX_ONE;
                st_d      = StRound;
            end
            StRound: begin
                busy_o    = 1'b1;
                key_idx_o = rnd_q;
                step      = StepRound;
                state_d   = step_out;
                rnd_d     = rnd_q - KIDX_ONE;
                if (rnd_q == KIDX_ONE) st_d = StFinal;
            end
            StFinal: begin
                busy_o    = 1'b1;
                key_idx_o = KIDX_LAST;
                step      = StepFinal;
                state_d   = step_out;
                st_d      = StDone;
            end
            StDone: begin
                out_valid_o = 1'b1;
                out_data_o  = state_q;
                // Output transfer and a new accept may share one edge.
                in_ready_o  = out_ready_i;
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        state_d = in_data_i;
                        st_d    = StInit;
                    end else begin
                        st_d = StIdle;
                    end
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_q    <= StIdle;
            state_q <= '0;
            rnd_q   <= '0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Directed and randomised bench for aes_dec_iter_ctrl against an independent table-based AES model.
module tb_aes_dec_iter_ctrl;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] GARBAGE = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] rk [16];
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [7:0]   exp_t [256];
    logic [7:0]   log_t [256];

    int n_checks = 0;
    int n_errors = 0;

    assign round_key = rk[key_idx];

    aes_dec_iter_ctrl dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .key_idx_o  (key_idx),
        .round_key_i(round_key),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
    endfunction

    task automatic build_tables();
        logic [7:0] x, inv, s;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = 8'(i);
            x = x ^ xt(x);
        end
        exp_t[255] = 8'h01;
        log_t[0]   = 8'h00;
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : exp_t[255 - int'(log_t[a])];
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[a]     = s;
            isbox[s]    = 8'(a);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook inverse cipher order: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] blk;
        blk = ct ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            for (int k = 0; k < 16; k++) s[k] = blk[127-8*k -: 8];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++) t[rr+4*c] = isbox[s[rr+4*((c-rr+4)%4)]];
            for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = t[k];
            blk = blk ^ rk[r];
            if (r > 0) begin
                for (int k = 0; k < 16; k++) s[k] = blk[127-8*k -: 8];
                for (int c = 0; c < 4; c++) begin
                    t[4*c]   = gmul(s[4*c], 14) ^ gmul(s[4*c+1], 11) ^ gmul(s[4*c+2], 13)
                             ^ gmul(s[4*c+3], 9);
                    t[4*c+1] = gmul(s[4*c], 9) ^ gmul(s[4*c+1], 14) ^ gmul(s[4*c+2], 11)
                             ^ gmul(s[4*c+3], 13);
                    t[4*c+2] = gmul(s[4*c], 13) ^ gmul(s[4*c+1], 9) ^ gmul(s[4*c+2], 14)
                             ^ gmul(s[4*c+3], 11);
                    t[4*c+3] = gmul(s[4*c], 11) ^ gmul(s[4*c+1], 13) ^ gmul(s[4*c+2], 9)
                             ^ gmul(s[4*c+3], 14);
                end
                for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = t[k];
            end
        end
        return blk;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_out_data"}, out_data, 0);
        check_eq({tag, "_key_idx"}, key_idx, 0);
    endtask

    // Accept ct, step through INIT..FINAL checking key_idx, then check the DONE cycle.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                             input logic [15:0] glitch);
        in_valid = 1'b1; in_data = ct; out_ready = 1'b1; #1;
        check_eq("accept_ready", in_ready, 1);
        tick();
        for (int c = 1; c <= 11; c++) begin
            in_valid = glitch[c];
            in_data  = glitch[c] ? GARBAGE : '0;
            #1;
            check_eq("key_idx", key_idx, (c == 1) ? 10 : (c == 11) ? 0 : 11 - c);
            check_eq("busy_run", busy, 1);
            check_eq("early_valid", out_valid, 0);
            tick();
        end
        in_valid = 1'b0; #1;
        check_eq("done_valid", out_valid, 1);
        check_eq("done_data", out_data, pt);
        tick(); #1;
        check_idle("after_xfer");
    endtask

    initial begin
        logic [127:0] pt_zero, key, ct, exp_pt;
        logic         bad;
        int           stall;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) rk[i] = '0;
        build_tables();
        expand_key(C1_KEY);
        check_eq("model_rk10", rk[10], C1_RK10);
        check_eq("model_c1", model_dec(C1_CT), C1_PT);
        pt_zero = model_dec('0);

        tick(); tick(); #1;
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.1 with a one-cycle in_valid
        run_block(C1_CT, C1_PT, 16'h0000);

        // Backpressure: DONE held for 20 cycles, a stray in_valid ignored
        in_valid = 1'b1; in_data = C1_CT; out_ready = 1'b0;
        tick(); in_valid = 1'b0;
        for (int c = 1; c <= 11; c++) tick();
        for (int c = 0; c < 20; c++) begin
            in_valid = (c == 5); in_data = (c == 5) ? GARBAGE : '0; #1;
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_data", out_data, C1_PT);
            check_eq("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; #1;
        check_eq("bp_release_ready", in_ready, 1);
        tick(); #1;
        check_idle("bp_after");

        // Back-to-back: second block accepted in the first block's DONE cycle
        in_valid = 1'b1; in_data = C1_CT; out_ready = 1'b1;
        tick(); in_data = '0;
        bad = 1'b0;
        for (int c = 1; c <= 11; c++) begin #1; if (out_valid || !busy) bad = 1'b1; tick(); end
        check_eq("b2b_first_busy", bad, 0);
        #1;
        check_eq("b2b_first_valid", out_valid, 1);
        check_eq("b2b_first_data", out_data, C1_PT);
        check_eq("b2b_ready_in_done", in_ready, 1);
        tick(); in_valid = 1'b0;
        for (int c = 13; c <= 23; c++) begin #1; if (out_valid || !busy) bad = 1'b1; tick(); end
        check_eq("b2b_gap", bad, 0);
        #1;
        check_eq("b2b_second_valid", out_valid, 1);
        check_eq("b2b_second_data", out_data, pt_zero);
        tick(); #1;
        check_idle("b2b_after");

        // Reset in cycle 6 after accept discards the block
        in_valid = 1'b1; in_data = C1_CT;
        tick(); in_valid = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        rst_n = 1'b0;
        tick(); #1;
        check_idle("mid_reset");
        rst_n = 1'b1;
        run_block(C1_CT, C1_PT, 16'h0000);

        // Garbage in_valid pulses in cycles 3 and 8 while busy
        run_block(C1_CT, C1_PT, 16'h0108);

        // Random keys and ciphertexts with random output stalls
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            ct  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            exp_pt = model_dec(ct);
            bad = 1'b0;
            in_valid = 1'b1; in_data = ct; out_ready = 1'($urandom_range(0, 1)); #1;
            if (!in_ready || out_valid) bad = 1'b1;
            tick(); in_valid = 1'b0;
            for (int c = 1; c <= 11; c++) begin
                out_ready = 1'($urandom_range(0, 1)); #1;
                if (out_valid) bad = 1'b1;
                tick();
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                out_ready = 1'b0; #1;
                if (!out_valid || out_data !== exp_pt) bad = 1'b1;
                tick();
            end
            out_ready = 1'b1; #1;
            check_eq("rand_data", out_data, exp_pt);
            if (!out_valid) bad = 1'b1;
            check_eq("rand_handshake", bad, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
